// File: rtl/pc_sequencer.sv
// Fetch/sequence controller for the ProgramCounter: instruction-memory handshake, decode
// hand-off, and PC update (increment, branch, call, return) with a small return-address stack.
module pc_sequencer #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [WIDTH:0]     pc,
  output logic               load_pc,
  output logic               inc_pc,
  output logic [WIDTH:0]     pc_val,
  output logic               imem_req,
  output logic [WIDTH:0]     imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  input  logic               ex_done,
  input  logic               redirect,
  input  logic [WIDTH:0]     target,
  input  logic               call,
  input  logic               ret,
  input  logic               halt_req,
  output logic               halted,
  output logic               stack_err
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH);
  localparam logic [PtrW:0] SpFull = (PtrW + 1)'(STACK_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StExec,
    StUpdate,
    StHalt
  } state_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [WIDTH:0]       pc_val_q, pc_val_d;
  logic                 upd_load_q, upd_load_d;
  logic                 halt_q, halt_d;
  logic                 err_q, err_d;
  logic [PtrW:0]        sp_q, sp_d;
  logic [WIDTH:0]       stack_q [STACK_DEPTH];
  logic [WIDTH:0]       stack_d [STACK_DEPTH];

  logic [WIDTH:0]       pc_inc;
  logic [PtrW:0]        sp_dec;

  assign pc_inc = pc + {{WIDTH{1'b0}}, 1'b1};
  assign sp_dec = sp_q - {{PtrW{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_val_d   = pc_val_q;
    upd_load_d = upd_load_q;
    halt_d     = halt_q;
    err_d      = err_q;
    sp_d       = sp_q;
    stack_d    = stack_q;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) state_d = StExec;
      end
      StExec: begin
        if (ex_done) begin
          halt_d = halt_req;
          // Priority: ret, then redirect (optionally pushing), then plain increment.
          if (ret) begin
            if (sp_q == '0) begin
              err_d   = 1'b1;
              state_d = StHalt;
            end else begin
              pc_val_d   = stack_q[sp_dec[PtrW-1:0]];
              sp_d       = sp_dec;
              upd_load_d = 1'b1;
              state_d    = StUpdate;
            end
          end else if (redirect) begin
            if (call && (sp_q == SpFull)) begin
              err_d   = 1'b1;
              state_d = StHalt;
            end else begin
              if (call) begin
                stack_d[sp_q[PtrW-1:0]] = pc_inc;
                sp_d = sp_q + {{PtrW{1'b0}}, 1'b1};
              end
              pc_val_d   = target;
              upd_load_d = 1'b1;
              state_d    = StUpdate;
            end
          end else begin
            upd_load_d = 1'b0;
            state_d    = StUpdate;
          end
        end
      end
      StUpdate: begin
        state_d = halt_q ? StHalt : StFetch;
      end
      StHalt: begin
        if (run) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      pc_val_q   <= '0;
      upd_load_q <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      sp_q       <= '0;
      stack_q    <= '{default: '0};
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_val_q   <= pc_val_d;
      upd_load_q <= upd_load_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
      sp_q       <= sp_d;
      stack_q    <= stack_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = imem_req ? pc : '0;
  assign instr_valid = (state_q == StIssue);
  assign instr       = instr_q;
  assign load_pc     = (state_q == StUpdate) & upd_load_q;
  assign inc_pc      = (state_q == StUpdate) & ~upd_load_q;
  assign pc_val      = pc_val_q;
  assign halted      = (state_q == StHalt);
  assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: models the ProgramCounter and instruction memory, and
// checks fetch addresses and PC updates against a scoreboard of expected events.
module tb_pc_sequencer;

  localparam int W     = 11;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [W:0]    pc;
  logic          load_pc, inc_pc;
  logic [W:0]    pc_val;
  logic          imem_req;
  logic [W:0]    imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;
  logic          ex_done, redirect, call, ret, halt_req;
  logic [W:0]    target;
  logic          halted, stack_err;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(W), .INSTR_W(IW), .STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pc          (pc),
    .load_pc     (load_pc),
    .inc_pc      (inc_pc),
    .pc_val      (pc_val),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .ex_done     (ex_done),
    .redirect    (redirect),
    .target      (target),
    .call        (call),
    .ret         (ret),
    .halt_req    (halt_req),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  typedef enum int {EvFetch, EvLoad, EvInc} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [W:0] val;
  } ev_t;

  ev_t        ev_q[$];
  logic [W:0] stk[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic       req_prev = 1'b0;
  logic       sticky_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [W:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    ev_q.push_back(e);
  endtask

  task automatic pop_check(input ev_kind_e k, input logic [W:0] v, input string tag);
    ev_t e;
    if (ev_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(ev_q.size()), 32'd1);
      return;
    end
    e = ev_q.pop_front();
    check({tag, "_kind"}, 32'(k), 32'(e.kind));
    if (k != EvInc) check({tag, "_val"}, 32'(v), 32'(e.val));
  endtask

  // One cycle: sample at negedge, score DUT events, advance the ProgramCounter model.
  task automatic tick();
    @(negedge clk);
    if (imem_req && !req_prev) pop_check(EvFetch, imem_addr, "fetch_addr");
    if (load_pc || inc_pc) begin
      check("upd_exclusive", {31'b0, load_pc & inc_pc}, 32'd0);
      if (load_pc) begin
        pop_check(EvLoad, pc_val, "load_pc");
        pc = pc_val;
      end else begin
        pop_check(EvInc, pc, "inc_pc");
        pc = pc + 12'd1;
      end
    end
    req_prev = imem_req;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return imem_req;
      default: return halted;
    endcase
  endfunction

  task automatic wait_until(input int which, input string tag);
    for (int i = 0; i < 30 && !cond(which); i++) tick();
    check(tag, {31'b0, cond(which)}, 32'd1);
  endtask

  task automatic start();
    expect_ev(EvFetch, pc);
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic run_instr(input logic [IW-1:0] rdata, input int dly, input logic red,
                           input logic [W:0] tgt, input logic cl, input logic rt,
                           input logic hr);
    logic       err;
    logic [W:0] nxt;
    err = 1'b0;
    nxt = '0;
    wait_until(0, "wait_fetch");
    repeat (dly) begin
      tick();
      check("req_held", {31'b0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    check("instr", 32'(instr), 32'(rdata));
    tick();
    check("instr_hold", 32'(instr), 32'(rdata));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("issue_done", {31'b0, instr_valid}, 32'd0);
    // Control inputs without ex_done must be ignored.
    redirect = 1'b1;
    ret      = 1'b1;
    target   = 12'h7FF;
    tick();
    redirect = 1'b0;
    ret      = 1'b0;
    if (rt) begin
      if (stk.size() == 0) err = 1'b1;
      else begin
        nxt = stk.pop_back();
        expect_ev(EvLoad, nxt);
      end
    end else if (red) begin
      if (cl && stk.size() == DEPTH) err = 1'b1;
      else begin
        if (cl) stk.push_back(pc + 12'd1);
        nxt = tgt;
        expect_ev(EvLoad, nxt);
      end
    end else begin
      nxt = pc + 12'd1;
      expect_ev(EvInc, '0);
    end
    if (err) sticky_err = 1'b1;
    if (!err && !hr) expect_ev(EvFetch, nxt);
    ex_done  = 1'b1;
    redirect = red;
    target   = tgt;
    call     = cl;
    ret      = rt;
    halt_req = hr;
    tick();
    ex_done  = 1'b0;
    redirect = 1'b0;
    target   = '0;
    call     = 1'b0;
    ret      = 1'b0;
    halt_req = 1'b0;
    if (err || hr) begin
      if (!err) tick();
      check("halted", {31'b0, halted}, 32'd1);
      check("stack_err", {31'b0, stack_err}, {31'b0, sticky_err});
      tick();
      check("halt_no_req", {31'b0, imem_req}, 32'd0);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_upd"}, {30'b0, load_pc, inc_pc}, 32'd0);
    check({tag, "_halted"}, {31'b0, halted}, 32'd0);
    check({tag, "_instr"}, 32'(instr), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; ex_done = 1'b0; redirect = 1'b0; target = '0;
    call = 1'b0; ret = 1'b0; halt_req = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    check("reset_err", {31'b0, stack_err}, 32'd0);
    check("reset_pc_val", 32'(pc_val), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_no_run", {31'b0, imem_req}, 32'd0);

    // Basic fetch, 2-cycle ack, plain increment.
    start();
    run_instr(16'h1234, 2, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    // Branches, including the 0x010 -> 0x2A0 redirect.
    run_instr(16'hA001, 0, 1'b1, 12'h010, 1'b0, 1'b0, 1'b0);
    run_instr(16'hA002, 1, 1'b1, 12'h2A0, 1'b0, 1'b0, 1'b0);
    run_instr(16'hA003, 0, 1'b1, 12'h005, 1'b0, 1'b0, 1'b0);
    // Call from 0x005 to 0x100, return to 0x006.
    run_instr(16'hC100, 0, 1'b1, 12'h100, 1'b1, 1'b0, 1'b0);
    run_instr(16'hB000, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    // Five nested calls: the fifth overflows.
    run_instr(16'hC200, 0, 1'b1, 12'h200, 1'b1, 1'b0, 1'b0);
    run_instr(16'hC300, 0, 1'b1, 12'h300, 1'b1, 1'b0, 1'b0);
    run_instr(16'hC400, 0, 1'b1, 12'h400, 1'b1, 1'b0, 1'b0);
    run_instr(16'hC500, 0, 1'b1, 12'h500, 1'b1, 1'b0, 1'b0);
    run_instr(16'hC600, 0, 1'b1, 12'h600, 1'b1, 1'b0, 1'b0);
    check("overflow_pc_kept", 32'(pc), 32'h500);

    rst = 1'b0;
    stk.delete();
    sticky_err = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("err_cleared", {31'b0, stack_err}, 32'd0);

    // halt_req at 0x020, then resume at 0x021.
    pc = 12'h020;
    start();
    run_instr(16'h4000, 0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    tick();
    check("halt_stays", {31'b0, halted}, 32'd1);
    start();
    // Call from 0xFFF pushes 0x000; return there.
    run_instr(16'hA004, 0, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0);
    run_instr(16'hC050, 0, 1'b1, 12'h050, 1'b1, 1'b0, 1'b0);
    run_instr(16'hB001, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    check("wrap_pc", 32'(pc), 32'h000);
    run_instr(16'hC051, 0, 1'b1, 12'h050, 1'b1, 1'b0, 1'b0);

    // Reset while fetching with a non-empty stack; a late ack must be ignored.
    wait_until(0, "wait_fetch_rst");
    rst = 1'b0;
    #1;
    check_quiet("async_rst");
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    check_quiet("late_ack");
    imem_ack   = 1'b0;
    imem_rdata = '0;
    stk.delete();
    sticky_err = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_idle", {31'b0, imem_req}, 32'd0);
    start();
    // Stack was flushed, so this return underflows.
    run_instr(16'hB002, 0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    check("underflow_pc_kept", 32'(pc), 32'h050);

    repeat (3) tick();
    check("scoreboard_drained", 32'(ev_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
